// File: rtl/key_switch_input.sv
`default_nettype none
// ============================================================================
// Module      : key_switch_input
// Description : Memory-mapped input port for the board slide switches and the
//               general-purpose push-buttons. Switches are synchronized and
//               sampled as-is. Push-buttons are synchronized, debounced and
//               their press events are latched into sticky flags that the CPU
//               collects through a single-strobe read with 1-cycle latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_50        in   1        system clock, rising-edge active
//   reset           in   1        synchronous, active-high reset
//   SW              in   N_SW     raw slide switches (asynchronous)
//   KEY_N           in   N_KEYS   raw push-buttons, active-low (asynchronous)
//   CONTROL_IOREAD  in   1        read strobe, sampled every edge
//   IO_ADDR         in   2        register select, sampled with the strobe
//   IO_READ_DATA    out  32       registered read data, held between reads
//   IO_READ_VALID   out  1        one-cycle pulse marking a completed read
//   KEY_STATE       out  N_KEYS   debounced key levels, 1 = pressed
//   IRQ             out  1        high while any pending flag is set
// ----------------------------------------------------------------------------
// Register map
//   0 : synchronized switches, zero-extended
//   1 : KEY_STATE in [N_KEYS-1:0]
//   2 : pending in [N_KEYS-1:0], overflow in [8+N_KEYS-1:8], read-to-clear
//   3 : reads 0
// ============================================================================
module key_switch_input #(
    parameter int N_SW            = 18,
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic [N_SW-1:0]   SW,
    input  logic [N_KEYS-1:0] KEY_N,
    input  logic              CONTROL_IOREAD,
    input  logic [1:0]        IO_ADDR,
    output logic [31:0]       IO_READ_DATA,
    output logic              IO_READ_VALID,
    output logic [N_KEYS-1:0] KEY_STATE,
    output logic              IRQ
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Terminal count: the mismatch sample seen while the counter sits here is
    // the DEBOUNCE_CYCLES-th consecutive one, so the level is accepted.
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ADDR_SW     = 2'd0;
    localparam logic [1:0] c_ADDR_KEYS   = 2'd1;
    localparam logic [1:0] c_ADDR_EVENTS = 2'd2;

    // Bit offset of the overflow field in the events register.
    localparam int c_OVF_LSB = 8;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------------
    // Keys are inverted before the first flop so that every key signal past
    // this point is active-high and a cleared synchronizer reads "released",
    // which matches the cleared stable level and avoids a spurious press
    // event straight out of reset.
    logic [N_SW-1:0]   r_sw_sync1;
    logic [N_SW-1:0]   r_sw_sync2;
    logic [N_KEYS-1:0] r_key_sync1;
    logic [N_KEYS-1:0] r_key_sync2;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
            r_key_sync1 <= '0;
            r_key_sync2 <= '0;
        end else begin
            r_sw_sync1  <= SW;
            r_sw_sync2  <= r_sw_sync1;
            r_key_sync1 <= ~KEY_N;
            r_key_sync2 <= r_key_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-key debounce
    // ------------------------------------------------------------------------
    // Each key owns a counter of consecutive samples in which the synchronized
    // level differs from the accepted (stable) level. Any agreeing sample
    // restarts the run, so a glitch shorter than DEBOUNCE_CYCLES samples never
    // reaches the stable level.
    logic [N_KEYS-1:0] w_key_stable;
    logic [N_KEYS-1:0] w_press_evt;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_stable;
            logic               w_mismatch;
            logic               w_accept;

            assign w_mismatch = r_key_sync2[gi] ^ r_stable;
            assign w_accept   = w_mismatch && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clock_50) begin
                if (reset) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (!w_mismatch) begin
                    r_cnt    <= '0;
                end else if (w_accept) begin
                    r_cnt    <= '0;
                    r_stable <= ~r_stable;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            end

            assign w_key_stable[gi] = r_stable;
            // Only released->pressed transitions are events; releases are
            // visible through KEY_STATE alone.
            assign w_press_evt[gi]  = w_accept && !r_stable;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sticky event flags with read-to-clear
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] r_pending;
    logic [N_KEYS-1:0] r_overflow;
    logic              w_rd_events;
    logic [N_KEYS-1:0] w_pend_clr;
    logic [N_KEYS-1:0] w_ovf_clr;
    logic [N_KEYS-1:0] w_pend_keep;
    logic [N_KEYS-1:0] w_ovf_keep;

    assign w_rd_events = CONTROL_IOREAD && (IO_ADDR == c_ADDR_EVENTS);

    // A read clears exactly the bits it returns, i.e. the pre-edge values.
    assign w_pend_clr  = w_rd_events ? r_pending  : '0;
    assign w_ovf_clr   = w_rd_events ? r_overflow : '0;
    assign w_pend_keep = r_pending  & ~w_pend_clr;
    assign w_ovf_keep  = r_overflow & ~w_ovf_clr;

    // A press landing on the same edge as a clearing read survives as a fresh
    // pending flag; it only counts as an overflow when the previous pending
    // flag is still standing after the clear.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= w_pend_keep | w_press_evt;
            r_overflow <= w_ovf_keep  | (w_press_evt & w_pend_keep);
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    logic [31:0] w_sel_data;

    always_comb begin
        w_sel_data = '0;
        case (IO_ADDR)
            c_ADDR_SW: begin
                w_sel_data[N_SW-1:0] = r_sw_sync2;
            end
            c_ADDR_KEYS: begin
                w_sel_data[N_KEYS-1:0] = w_key_stable;
            end
            c_ADDR_EVENTS: begin
                w_sel_data[N_KEYS-1:0]           = r_pending;
                w_sel_data[c_OVF_LSB +: N_KEYS]  = r_overflow;
            end
            default: begin
                w_sel_data = '0;
            end
        endcase
    end

    logic [31:0] r_rd_data;
    logic        r_rd_valid;

    // Data holds between reads; the valid flag simply mirrors the strobe one
    // cycle later so back-to-back strobes give back-to-back pulses.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= CONTROL_IOREAD;
            if (CONTROL_IOREAD) begin
                r_rd_data <= w_sel_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all sourced from flops)
    // ------------------------------------------------------------------------
    assign IO_READ_DATA  = r_rd_data;
    assign IO_READ_VALID = r_rd_valid;
    assign KEY_STATE     = w_key_stable;
    assign IRQ           = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_key_switch_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_switch_input
// Description : Self-checking bench for key_switch_input with a short
//               debounce window. Reads push their expected data into a
//               scoreboard queue; a monitor pops and compares on every
//               IO_READ_VALID pulse. Key levels and IRQ are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_switch_input;

    localparam int N_SW   = 18;
    localparam int N_KEYS = 3;
    localparam int DEB    = 4;

    logic              clk;
    logic              rst;
    logic [N_SW-1:0]   sw;
    logic [N_KEYS-1:0] key_n;
    logic              rd;
    logic [1:0]        addr;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [N_KEYS-1:0] key_state;
    logic              irq;

    key_switch_input #(
        .N_SW            (N_SW),
        .N_KEYS          (N_KEYS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock_50       (clk),
        .reset          (rst),
        .SW             (sw),
        .KEY_N          (key_n),
        .CONTROL_IOREAD (rd),
        .IO_ADDR        (addr),
        .IO_READ_DATA   (rdata),
        .IO_READ_VALID  (rvalid),
        .KEY_STATE      (key_state),
        .IRQ            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a one-cycle read strobe and record the expected returned data.
    task automatic rd_issue(input logic [1:0] a, input logic [31:0] e, input string nm);
        rd   = 1'b1;
        addr = a;
        sb_q.push_back(e);
        name_q.push_back(nm);
        step(1);
        rd   = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding read.
    always @(posedge clk) begin
        #1;
        if (rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_valid: got VALID=1 data=0x%08h expected no outstanding read", rdata);
            end else begin
                mon_exp  = sb_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, rdata, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        sw    = '0;
        key_n = 3'b000;
        rd    = 1'b0;
        addr  = 2'd0;

        // Reset while all keys are held down.
        step(2);
        check("reset_rdata",     rdata,     32'h0);
        check("reset_valid",     rvalid,    32'h0);
        check("reset_key_state", key_state, 32'h0);
        check("reset_irq",       irq,       32'h0);

        // Held keys are accepted at post-release edge 5 (edges counted from 0).
        rst = 1'b0;
        step(5);
        check("pwr_keys_early",  key_state, 32'h0);
        check("pwr_irq_early",   irq,       32'h0);
        step(1);
        check("pwr_keys",        key_state, 32'h7);
        check("pwr_irq",         irq,       32'h1);
        rd_issue(2'd2, 32'h0000_0007, "pwr_events");
        check("pwr_irq_cleared", irq,       32'h0);
        key_n = 3'b111;
        step(8);
        check("pwr_released",    key_state, 32'h0);
        check("pwr_release_irq", irq,       32'h0);

        // Bounce: three low samples on key 0 are rejected.
        key_n = 3'b110;
        step(3);
        key_n = 3'b111;
        step(10);
        check("bounce_key_state", key_state, 32'h0);
        check("bounce_irq",       irq,       32'h0);
        rd_issue(2'd2, 32'h0000_0000, "bounce_events");

        // Clean press of key 1.
        key_n = 3'b101;
        step(5);
        check("press_key_early", key_state, 32'h0);
        step(1);
        check("press_key_state", key_state, 32'h2);
        check("press_irq",       irq,       32'h1);
        step(4);
        rd_issue(2'd2, 32'h0000_0002, "press_events");
        check("press_irq_clr",   irq,       32'h0);
        step(1);
        check("valid_one_cycle", rvalid,    32'h0);
        rd_issue(2'd2, 32'h0000_0000, "press_events_again");
        key_n = 3'b111;
        step(8);

        // Two presses of key 2 without a read in between.
        key_n = 3'b011;
        step(8);
        key_n = 3'b111;
        step(8);
        key_n = 3'b011;
        step(8);
        key_n = 3'b111;
        step(8);
        rd_issue(2'd2, 32'h0000_0404, "ovf_events");
        rd_issue(2'd2, 32'h0000_0000, "ovf_events_again");
        check("ovf_irq_clr", irq, 32'h0);

        // Read of the events register on the edge key 0's press is accepted.
        key_n = 3'b110;
        step(5);
        rd_issue(2'd2, 32'h0000_0000, "collide_events");
        check("collide_key_state", key_state, 32'h1);
        check("collide_irq",       irq,       32'h1);
        rd_issue(2'd1, 32'h0000_0001, "collide_key_reg");
        rd_issue(2'd2, 32'h0000_0001, "collide_pending");
        check("collide_irq_clr",   irq,       32'h0);
        rd_issue(2'd3, 32'h0000_0000, "addr3");
        key_n = 3'b111;
        step(8);

        // Switches.
        sw = 18'h2A5A5;
        step(3);
        rd_issue(2'd0, 32'h0002_A5A5, "switches");

        // Reset in the middle of a debounce run on key 1.
        key_n = 3'b101;
        step(4);
        rst = 1'b1;
        step(1);
        check("midrst_rdata", rdata,  32'h0);
        check("midrst_valid", rvalid, 32'h0);
        rst = 1'b0;
        step(5);
        check("midrst_key_early", key_state, 32'h0);
        check("midrst_irq_early", irq,       32'h0);
        step(1);
        check("midrst_key_state", key_state, 32'h2);
        check("midrst_irq",       irq,       32'h1);
        rd_issue(2'd2, 32'h0000_0002, "midrst_events");
        rd_issue(2'd0, 32'h0002_A5A5, "midrst_switches");

        step(3);
        check("sb_drained", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_switch_input.md
Name: key_switch_input

Overview:
- Memory-mapped input peripheral; the read-side counterpart of the LED output port.
- Synchronizes and samples the board slide switches.
- Synchronizes and debounces the push-buttons not used for CPU stepping, and latches button-press events into sticky flags.
- The CPU reads all of this through a single-strobe read handshake with one-cycle latency.

Parameters:
- N_SW, 18, number of slide switches (1..32).
- N_KEYS, 3, number of debounced push-buttons (1..8).
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a key level change (>=2).

Ports:
- clock_50  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- SW  in  N_SW  raw slide switches, asynchronous.
- KEY_N  in  N_KEYS  raw push-buttons, asynchronous, active-low (0 = pressed).
- CONTROL_IOREAD  in  1  read strobe from the CPU, sampled each edge.
- IO_ADDR  in  2  register select, sampled with CONTROL_IOREAD.
- IO_READ_DATA  out  32  registered read data.
- IO_READ_VALID  out  1  one-cycle pulse; IO_READ_DATA is valid.
- KEY_STATE  out  N_KEYS  debounced level, 1 = pressed.
- IRQ  out  1  high while any pending flag is set.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all synchronizer flops and debounce counters.
  - Clears stable levels (released), pending[] and overflow[].
  - Clears IO_READ_DATA and IO_READ_VALID. KEY_STATE=0, IRQ=0.
  - A reset during a debounce count discards the count; no event is generated.
- Synchronization: every SW and KEY_N bit passes through a 2-flop synchronizer.
- Switches: not debounced; read value = synchronized SW, zero-extended to 32 bits.
- Debounce, one counter per key, width clog2(DEBOUNCE_CYCLES):
  - If the synchronized level equals the stable level, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and the mismatch persists, the stable level flips and the counter clears.
  - A mismatch run shorter than DEBOUNCE_CYCLES samples changes nothing.
- Latency: a raw edge captured in sync stage 1 at edge 0 flips the stable level at edge DEBOUNCE_CYCLES+1.
- Press event (stable released->pressed):
  - Sets pending[i] at the same edge the stable level flips.
  - If pending[i] is already 1 at that edge, overflow[i] is set instead (pending stays 1).
  - Release transitions generate no event.
- Register map; reads have 1-cycle latency:
  - 0: synchronized switches.
  - 1: KEY_STATE in bits [N_KEYS-1:0].
  - 2: events. pending in [N_KEYS-1:0], overflow in [8+N_KEYS-1:8]. Read-to-clear.
  - 3: reads 0.
  - All unused bits read 0.
- Read handshake:
  - At an edge with CONTROL_IOREAD=1, IO_READ_DATA loads the selected value as it was before that edge, and IO_READ_VALID=1 for exactly that cycle.
  - IO_READ_DATA then holds until the next read.
  - A read of address 2 clears every pending/overflow bit that was returned.
- Simultaneous read and event:
  - If a press event for key i occurs at the same edge as an address-2 read, the new event wins: pending[i]=1 after the edge.
  - The returned data shows the pre-edge value.
  - Overflow is set only if pending[i] was 1 and is not being cleared.
- Back-to-back reads on consecutive cycles are legal; each returns and clears independently.
- IRQ = OR of pending[], driven from registers (no combinational path from the inputs).

Test Plan:
- Reset with DEBOUNCE_CYCLES=4:
  - Assert reset 2 cycles while KEY_N=3'b000 -> IO_READ_DATA=0, IO_READ_VALID=0, KEY_STATE=0, IRQ=0.
  - After release, KEY_STATE=3'b111 at edge 5 post-release; pending=3'b111, IRQ=1.
- Bounce rejection: KEY_N[0] low for 3 cycles, then high -> KEY_STATE[0] stays 0, pending stays 0, read of address 2 returns 0x00000000.
- Clean press:
  - KEY_N[1] falls, held 10 cycles -> KEY_STATE[1]=1 exactly 5 edges after stage-1 capture; IRQ=1.
  - Read address 2 -> data 0x00000002, VALID pulse 1 cycle; next address-2 read returns 0; IRQ=0.
- Overflow: two debounced presses of KEY_N[2] with no read between -> address 2 returns 0x00000404; a following read returns 0.
- Collision: address-2 read at the same edge KEY_N[0]'s press is accepted -> returned data 0x00000000, pending[0]=1 afterwards, IRQ stays 1.
- Switches and reset mid-debounce:
  - SW=18'h2A5A5, read address 0 three cycles later -> 0x0002A5A5.
  - Assert reset during a 3-cycle debounce count, then continue holding the key -> no event until DEBOUNCE_CYCLES full samples after reset release.
